fir_decim_round: RTL and testbench

- Output stage placed directly downstream of the FIR filter. Consumes the filter's full-precision valid/data stream.
- Decimates by an integer factor, rounds, and saturates to a narrower word.
- Buffers the results in a small FIFO so that a downstream consumer with ready backpressure can drain them.
- The upstream filter has no backpressure, so this block must sample every valid_in.

---
 rtl/fir_decim_pkg.sv | 58 +++++
 rtl/fir_sync_fifo.sv | 60 ++++++
 rtl/fir_decim_round.sv | 178 +++++++++++++++++
 tb/tb_fir_decim_round.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_decim_pkg.sv
// ---------------------------------------------------------------------------
// fir_decim_pkg
//   Shared types and helpers for the FIR output stage (fir_decim_round) and
//   its FIFO (fir_sync_fifo).
//   - in_t / out_t : default-width signed sample types (26-bit in, 16-bit out)
//   - ptr_width()  : FIFO pointer width rule, log2(depth)+1 (extra wrap bit)
//   - round_shift(): round-half-up and arithmetic shift right
//   - sat_to_width(): clamp to a signed width, returns {clip, value}
//   The helpers work on a 64-bit signed carrier so that any module width up
//   to 63 bits can use them. The caller size-casts the result.
// ---------------------------------------------------------------------------
package fir_decim_pkg;

    localparam int IN_W  = 26;
    localparam int OUT_W = 16;
    localparam int WIDE  = 64;

    typedef logic signed [IN_W-1:0]  in_t;
    typedef logic signed [OUT_W-1:0] out_t;
    typedef logic signed [WIDE-1:0]  wide_t;

    // Pointer carries one extra MSB so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Adds half an LSB of the result, then floors: ties go toward +inf.
    function automatic wide_t round_shift(input wide_t x, input int shift);
        wide_t half;
        half = wide_t'(1) <<< (shift - 1);
        return (x + half) >>> shift;
    endfunction

    // Result layout: bit [width] is the clip flag, bits [width-1:0] hold the
    // clamped value; all bits above are zero.
    function automatic logic [WIDE:0] sat_to_width(input wide_t x, input int width);
        wide_t         hi;
        wide_t         lo;
        wide_t         v;
        logic          clip;
        logic [WIDE:0] res;
        hi   = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        lo   = -hi - wide_t'(1);
        v    = x;
        clip = 1'b0;
        if (x > hi) begin
            v    = hi;
            clip = 1'b1;
        end else if (x < lo) begin
            v    = lo;
            clip = 1'b1;
        end
        res        = {1'b0, v & ((wide_t'(1) <<< width) - wide_t'(1))};
        res[width] = clip;
        return res;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// ---------------------------------------------------------------------------
// fir_sync_fifo
//   Small synchronous FIFO with show-ahead head output.
//   Ports:
//     clk, rst (async active-low)
//     push, din   : write request and data; accepted when not full, or when
//                   full and a pop happens in the same cycle
//     pop         : read request; ignored when empty
//     head        : current oldest entry (valid while !empty)
//     full, empty : status
//   DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module fir_sync_fifo
    import fir_decim_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int AW    = PTR_W - 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: storage has no reset; pointers alone define which entries are
    // live, and a reset array would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fir_decim_round.sv
// ---------------------------------------------------------------------------
// fir_decim_round
//   Output stage behind the FIR filter: keeps one sample in every DECIM,
//   rounds away SHIFT LSBs (half-up), saturates to OUTPUT_WIDTH and buffers
//   the result in a FIFO drained with valid/ready.
//   Ports:
//     clk, rst (async active-low)
//     valid_in, din  : filter stream, no backpressure
//     phase_clr      : restart decimation phase (sample in same cycle is ph 0)
//     valid_out, dout, ready_in : FIFO head handshake
//     sat            : pulse, a clipped sample reached the FIFO write point
//     overflow       : sticky, a kept sample was dropped on a full FIFO
//     clr_ovf        : clears overflow (a same-cycle drop wins)
//     sat_count      : clip event counter
//   Build option: define FIR_DECIM_SATCNT_EN to implement sat_count; when
//   undefined sat_count is tied to zero.
//   Latency: valid_in at cycle N -> FIFO write at end of N+2 -> valid_out
//   from N+3 when the FIFO was empty.
// ---------------------------------------------------------------------------
module fir_decim_round
    import fir_decim_pkg::*;
#(
    parameter int INPUT_WIDTH  = 26,
    parameter int OUTPUT_WIDTH = 16,
    parameter int SHIFT        = 10,
    parameter int DECIM        = 4,
    parameter int PHASE        = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic signed [INPUT_WIDTH-1:0]  din,
    input  logic                           phase_clr,
    output logic                           valid_out,
    input  logic                           ready_in,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    output logic                           sat,
    output logic                           overflow,
    input  logic                           clr_ovf,
    output logic [15:0]                    sat_count
);

    localparam int RND_W = INPUT_WIDTH + 1 - SHIFT;
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    // ---------------- decimation phase ----------------
    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_cur;
    logic [PH_W-1:0] ph_nxt;
    logic            keep;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        ph_cur = phase_clr ? '0 : ph;
        keep   = valid_in && (ph_cur == PH_W'(PHASE));
        ph_nxt = ph_cur;
        if (valid_in) begin
            ph_nxt = (ph_cur == PH_W'(DECIM - 1)) ? '0 : ph_cur + PH_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ph <= '0;
        else      ph <= ph_nxt;
    end

    // ---------------- stage 1: round ----------------
    logic                    s1_valid;
    logic signed [RND_W-1:0] s1_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_val   <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) s1_val <= RND_W'(round_shift(wide_t'(din), SHIFT));
        end
    end

    // ---------------- stage 2: saturate ----------------
    logic                           s2_clip_d;
    logic signed [OUTPUT_WIDTH-1:0] s2_val_d;
    logic                           s2_valid;
    logic                           s2_clip;
    logic signed [OUTPUT_WIDTH-1:0] s2_val;

    generate
        if (RND_W > OUTPUT_WIDTH) begin : g_clip
            assign {s2_clip_d, s2_val_d} =
                (OUTPUT_WIDTH + 1)'(sat_to_width(wide_t'(s1_val), OUTPUT_WIDTH));
        end else begin : g_noclip
            // The rounded value always fits: nothing can clip.
            assign s2_clip_d = 1'b0;
            assign s2_val_d  = OUTPUT_WIDTH'(s1_val);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_clip  <= 1'b0;
            s2_val   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_clip <= s2_clip_d;
                s2_val  <= s2_val_d;
            end
        end
    end

    // ---------------- output FIFO ----------------
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    drop;
    logic [OUTPUT_WIDTH-1:0] fifo_head;
    logic [OUTPUT_WIDTH-1:0] last_q;

    assign valid_out = !fifo_empty;
    assign pop       = valid_out && ready_in;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign drop      = s2_valid && fifo_full && !pop;

    fir_sync_fifo #(
        .WIDTH (OUTPUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_valid),
        .din   (s2_val),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Once drained, dout keeps showing the last value handed downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     last_q <= '0;
        else if (pop) last_q <= fifo_head;
    end

    assign dout = valid_out ? $signed(fifo_head) : $signed(last_q);

    // ---------------- flags ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sat <= s2_valid && s2_clip;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

`ifdef FIR_DECIM_SATCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_count <= '0;
        end else if (clr_ovf) begin
            sat_count <= '0;
        end else if (s2_valid && s2_clip && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_fir_decim_round.sv
// ---------------------------------------------------------------------------
// tb_fir_decim_round
//   Two instances share the stimulus: dut_a runs at DECIM=1, dut_b at
//   DECIM=4/PHASE=0. Directed tables and sequences cover rounding,
//   saturation, decimation, backpressure, overflow and reset; a randomized
//   run is scored against an arithmetic model of the output stream.
// ---------------------------------------------------------------------------
module tb_fir_decim_round;
    import fir_decim_pkg::*;

    typedef struct {
        longint din;
        longint exp_dout;
        logic   exp_sat;
    } vec_t;

`ifdef FIR_DECIM_SATCNT_EN
    localparam bit SATCNT = 1'b1;
`else
    localparam bit SATCNT = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  valid_in = 1'b0;
    logic  phase_clr = 1'b0;
    logic  ready_in = 1'b0;
    logic  clr_ovf = 1'b0;
    in_t   din = '0;

    logic        valid_out_a, sat_a, overflow_a;
    out_t        dout_a;
    logic [15:0] sat_count_a;
    logic        valid_out_b, sat_b, overflow_b;
    out_t        dout_b;
    logic [15:0] sat_count_b;

    int total = 0;
    int bad   = 0;

    longint got_a[$];
    longint got_b[$];
    int     sat_pulses_a = 0;
    int     sat_pulses_b = 0;

    always #5 clk = ~clk;

    fir_decim_round #(.DECIM(1), .PHASE(0)) dut_a (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .phase_clr(phase_clr),
        .valid_out(valid_out_a), .ready_in(ready_in), .dout(dout_a), .sat(sat_a),
        .overflow(overflow_a), .clr_ovf(clr_ovf), .sat_count(sat_count_a)
    );

    fir_decim_round #(.DECIM(4), .PHASE(0)) dut_b (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .phase_clr(phase_clr),
        .valid_out(valid_out_b), .ready_in(ready_in), .dout(dout_b), .sat(sat_b),
        .overflow(overflow_b), .clr_ovf(clr_ovf), .sat_count(sat_count_b)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint exp_cnt(input int n);
        return SATCNT ? longint'(n) : 64'sd0;
    endfunction

    // Expected output from plain arithmetic: floor((x + 512) / 1024), clamped.
    function automatic void model_out(input longint x, output longint y, output int clp);
        longint v;
        longint q;
        v = x + 512;
        if (v >= 0) q = v / 1024;
        else        q = -((-v + 1023) / 1024);
        clp = 0;
        if (q > 32767) begin
            q   = 32767;
            clp = 1;
        end else if (q < -32768) begin
            q   = -32768;
            clp = 1;
        end
        y = q;
    endfunction

    // One clock: observe at the falling edge, then step past the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (valid_out_a && ready_in) got_a.push_back(longint'(dout_a));
        if (valid_out_b && ready_in) got_b.push_back(longint'(dout_b));
        if (sat_a) sat_pulses_a++;
        if (sat_b) sat_pulses_b++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_in  = 1'b0;
        phase_clr = 1'b0;
        ready_in  = 1'b0;
        clr_ovf   = 1'b0;
        din       = '0;
        rst       = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        got_a.delete();
        got_b.delete();
        sat_pulses_a = 0;
        sat_pulses_b = 0;
    endtask

    task automatic push_val(input longint v);
        valid_in = 1'b1;
        din      = in_t'(v * 1024);
        cycle();
        valid_in = 1'b0;
    endtask

    // Sends one sample with ready_in=1 and records, per DUT, the first
    // cycle index (0 = the valid_in cycle) at which valid_out is seen.
    task automatic send_one(input longint x, output int lat_a, output longint val_a,
                            output logic sat_o, output int lat_b, output longint val_b);
        lat_a = -1; lat_b = -1; val_a = 0; val_b = 0; sat_o = 1'b0;
        valid_in = 1'b1;
        din      = in_t'(x);
        ready_in = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (valid_out_a && lat_a < 0) begin
                lat_a = k; val_a = longint'(dout_a); sat_o = sat_a;
            end
            if (valid_out_b && lat_b < 0) begin
                lat_b = k; val_b = longint'(dout_b);
            end
            @(posedge clk);
            #1 valid_in = 1'b0;
        end
    endtask

    initial begin
        vec_t   vecs[7];
        int     la, lb;
        longint va, vb;
        logic   sv;

        // ---------------- reset state ----------------
        do_reset();
        check("rst_valid_out", valid_out_a, 0);
        check("rst_dout", dout_a, 0);
        check("rst_overflow", overflow_a, 0);
        check("rst_sat", sat_a, 0);
        check("rst_sat_count", sat_count_a, 0);

        // ---------------- rounding and saturation (DECIM=1) ----------------
        vecs[0] = '{din: 511,       exp_dout: 0,      exp_sat: 1'b0};
        vecs[1] = '{din: 512,       exp_dout: 1,      exp_sat: 1'b0};
        vecs[2] = '{din: 1536,      exp_dout: 2,      exp_sat: 1'b0};
        vecs[3] = '{din: -1536,     exp_dout: -1,     exp_sat: 1'b0};
        vecs[4] = '{din: -513,      exp_dout: -1,     exp_sat: 1'b0};
        vecs[5] = '{din: 33554431,  exp_dout: 32767,  exp_sat: 1'b1};
        vecs[6] = '{din: -33554432, exp_dout: -32768, exp_sat: 1'b0};
        for (int i = 0; i < 7; i++) begin
            send_one(vecs[i].din, la, va, sv, lb, vb);
            check($sformatf("round_lat[%0d]", i), la, 3);
            check($sformatf("round_dout[%0d]", i), va, vecs[i].exp_dout);
            check($sformatf("round_sat[%0d]", i), sv, vecs[i].exp_sat);
        end
        check("sat_count_after_table", sat_count_a, exp_cnt(1));
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        check("sat_count_clr", sat_count_a, 0);

        // ---------------- decimation, DECIM=4 ----------------
        do_reset();
        ready_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(1) != 0) cycle();
            push_val(k);
        end
        repeat (8) cycle();
        check("decim_count", got_b.size(), 2);
        if (got_b.size() == 2) begin
            check("decim_out0", got_b[0], 0);
            check("decim_out1", got_b[1], 4);
        end

        do_reset();
        ready_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) begin
                phase_clr = 1'b1;
                cycle();
                phase_clr = 1'b0;
            end
            if ($urandom_range(1) != 0) cycle();
            push_val(k);
        end
        repeat (8) cycle();
        check("phclr_count", got_b.size(), 3);
        if (got_b.size() == 3) begin
            check("phclr_out0", got_b[0], 0);
            check("phclr_out1", got_b[1], 4);
            check("phclr_out2", got_b[2], 6);
        end

        // ---------------- backpressure / overflow ----------------
        do_reset();
        for (int v = 1; v <= 5; v++) push_val(v);
        repeat (5) cycle();
        check("bp_overflow_set", overflow_a, 1);
        check("bp_valid_out", valid_out_a, 1);
        ready_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid[%0d]", i), valid_out_a, 1);
            check($sformatf("bp_dout[%0d]", i), dout_a, i);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("bp_drained", valid_out_a, 0);
        check("bp_dout_hold", dout_a, 4);
        check("bp_overflow_sticky", overflow_a, 1);
        @(posedge clk);
        #1 clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        check("bp_overflow_clr", overflow_a, 0);

        // ---------------- full FIFO with simultaneous pop ----------------
        do_reset();
        for (int v = 10; v <= 13; v++) push_val(v);
        repeat (3) cycle();
        push_val(14);
        cycle();
        ready_in = 1'b1;
        cycle();
        ready_in = 1'b0;
        cycle();
        check("fullpop_overflow", overflow_a, 0);
        ready_in = 1'b1;
        repeat (6) cycle();
        check("fullpop_count", got_a.size(), 5);
        if (got_a.size() == 5) begin
            for (int i = 0; i < 5; i++) check($sformatf("fullpop_out[%0d]", i), got_a[i], 10 + i);
        end

        // ---------------- drop in the same cycle as clr_ovf ----------------
        do_reset();
        for (int v = 1; v <= 4; v++) push_val(v);
        repeat (3) cycle();
        push_val(5);
        cycle();
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        check("ovf_set_wins", overflow_a, 1);

        // ---------------- reset mid-operation ----------------
        do_reset();
        push_val(1);
        push_val(2);
        repeat (3) cycle();
        push_val(3);
        check("midrst_pre_valid", valid_out_a, 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_valid_a", valid_out_a, 0);
        check("midrst_valid_b", valid_out_b, 0);
        check("midrst_dout", dout_a, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        send_one(7 * 1024, la, va, sv, lb, vb);
        check("midrst_lat_a", la, 3);
        check("midrst_val_a", va, 7);
        check("midrst_lat_b", lb, 3);
        check("midrst_val_b", vb, 7);

        // ---------------- randomized run vs model ----------------
        begin
            longint exp_a[$];
            longint exp_b[$];
            int     b_idx  = 0;
            int     clip_a = 0;
            int     clip_b = 0;
            longint x, y;
            int     clp;

            do_reset();
            for (int c = 0; c < 1500; c++) begin
                ready_in  = ($urandom_range(3) != 0);
                phase_clr = ($urandom_range(15) == 0);
                valid_in  = 1'b0;
                if (phase_clr) b_idx = 0;
                if (exp_a.size() < 4 && exp_b.size() < 4 && $urandom_range(2) != 0) begin
                    if ($urandom_range(1) != 0) x = longint'(in_t'($urandom));
                    else                        x = longint'($urandom_range(4000000)) - 2000000;
                    din      = in_t'(x);
                    valid_in = 1'b1;
                    model_out(x, y, clp);
                    exp_a.push_back(y);
                    clip_a += clp;
                    if (b_idx % 4 == 0) begin
                        exp_b.push_back(y);
                        clip_b += clp;
                    end
                    b_idx++;
                end
                cycle();
                if (c >= 1480) begin
                    valid_in  = 1'b0;
                    phase_clr = 1'b0;
                end
                while (got_a.size() > 0) begin
                    if (exp_a.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rand_a_extra: got %0d expected nothing", got_a.pop_front());
                    end else begin
                        check("rand_a", got_a.pop_front(), exp_a.pop_front());
                    end
                end
                while (got_b.size() > 0) begin
                    if (exp_b.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rand_b_extra: got %0d expected nothing", got_b.pop_front());
                    end else begin
                        check("rand_b", got_b.pop_front(), exp_b.pop_front());
                    end
                end
            end
            valid_in  = 1'b0;
            phase_clr = 1'b0;
            ready_in  = 1'b1;
            repeat (10) cycle();
            while (got_a.size() > 0 && exp_a.size() > 0) check("rand_a_tail", got_a.pop_front(), exp_a.pop_front());
            while (got_b.size() > 0 && exp_b.size() > 0) check("rand_b_tail", got_b.pop_front(), exp_b.pop_front());
            check("rand_a_left", exp_a.size() + got_a.size(), 0);
            check("rand_b_left", exp_b.size() + got_b.size(), 0);
            check("rand_a_ovf", overflow_a, 0);
            check("rand_b_ovf", overflow_b, 0);
            check("rand_a_sat_pulses", sat_pulses_a, clip_a);
            check("rand_b_sat_pulses", sat_pulses_b, clip_b);
            check("rand_a_sat_count", sat_count_a, exp_cnt(clip_a));
            check("rand_b_sat_count", sat_count_b, exp_cnt(clip_b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
